// File: rtl/lockin_freq_sweep_master.sv
// Avalon-MM write master that sweeps the NCO tuning words of all lock-in channels.
// Each point writes every channel register back-to-back, then idles for a programmable dwell.
`timescale 1ns/1ps
module lockin_freq_sweep_master #(
  parameter int unsigned       CH_COUNT    = 8,
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       ADDR_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [19:0]       base_word,
  input  logic [19:0]       step_word,
  input  logic [19:0]       chan_spacing,
  input  logic [15:0]       num_points,
  input  logic [23:0]       dwell_cycles,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cur_point
);

  typedef enum logic [1:0] {StIdle, StWrite, StDwell, StFinish} state_e;

  state_e            state_q, state_d;
  logic [4:0]        ch_q, ch_d;
  logic [15:0]       point_q, point_d;
  logic [19:0]       word_q, word_d;
  logic [19:0]       ch_word_q, ch_word_d;
  logic [23:0]       dwell_cnt_q, dwell_cnt_d;
  logic [19:0]       step_q, step_d;
  logic [19:0]       spacing_q, spacing_d;
  logic [15:0]       npts_q, npts_d;
  logic [23:0]       dwell_q, dwell_d;
  logic              abort_pend_q, abort_pend_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic              avm_write_q, avm_write_d;
  logic [19:0]       avm_data_q, avm_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic        last_ch;
  logic        last_point;
  logic [19:0] next_word;
  logic [19:0] next_ch_word;
  logic        go_next;
  logic        go_finish;

  assign last_ch      = (ch_q == 5'(CH_COUNT - 1));
  // 17-bit compare so that a latched count of zero also reads as "last point".
  assign last_point   = (({1'b0, point_q} + 17'd1) >= {1'b0, npts_q});
  assign next_word    = word_q + step_q;
  assign next_ch_word = ch_word_q + spacing_q;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    point_d       = point_q;
    word_d        = word_q;
    ch_word_d     = ch_word_q;
    dwell_cnt_d   = dwell_cnt_q;
    step_d        = step_q;
    spacing_d     = spacing_q;
    npts_d        = npts_q;
    dwell_d       = dwell_q;
    abort_pend_d  = abort_pend_q;
    avm_address_d = avm_address_q;
    avm_write_d   = avm_write_q;
    avm_data_d    = avm_data_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    go_next       = 1'b0;
    go_finish     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          step_d       = step_word;
          spacing_d    = chan_spacing;
          npts_d       = num_points;
          dwell_d      = dwell_cycles;
          abort_pend_d = 1'b0;
          point_d      = '0;
          ch_d         = '0;
          word_d       = base_word;
          ch_word_d    = base_word;
          busy_d       = 1'b1;
          if (num_points == 16'd0) begin
            // Pass through an empty dwell so busy is seen for one cycle before done.
            state_d     = StDwell;
            dwell_cnt_d = '0;
          end else begin
            state_d       = StWrite;
            avm_write_d   = 1'b1;
            avm_address_d = BASE_ADDR;
            avm_data_d    = base_word;
          end
        end
      end

      StWrite: begin
        abort_pend_d = abort_pend_q | abort;
        if (!avm_waitrequest) begin
          if (abort_pend_q || abort) begin
            go_finish = 1'b1;
          end else if (!last_ch) begin
            ch_d          = ch_q + 5'd1;
            ch_word_d     = next_ch_word;
            avm_address_d = avm_address_q + ADDR_W'(ADDR_STRIDE);
            avm_data_d    = next_ch_word;
          end else if (dwell_q == 24'd0) begin
            go_next = 1'b1;
          end else begin
            state_d     = StDwell;
            dwell_cnt_d = dwell_q;
            avm_write_d = 1'b0;
          end
        end
      end

      StDwell: begin
        if (abort) begin
          go_finish = 1'b1;
        end else if (dwell_cnt_q <= 24'd1) begin
          go_next = 1'b1;
        end else begin
          dwell_cnt_d = dwell_cnt_q - 24'd1;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (go_next) begin
      if (last_point) begin
        go_finish = 1'b1;
      end else begin
        state_d       = StWrite;
        point_d       = point_q + 16'd1;
        word_d        = next_word;
        ch_d          = '0;
        ch_word_d     = next_word;
        avm_address_d = BASE_ADDR;
        avm_data_d    = next_word;
        avm_write_d   = 1'b1;
      end
    end

    if (go_finish) begin
      state_d      = StFinish;
      avm_write_d  = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b1;
      abort_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      point_q       <= '0;
      word_q        <= '0;
      ch_word_q     <= '0;
      dwell_cnt_q   <= '0;
      step_q        <= '0;
      spacing_q     <= '0;
      npts_q        <= '0;
      dwell_q       <= '0;
      abort_pend_q  <= 1'b0;
      avm_address_q <= '0;
      avm_write_q   <= 1'b0;
      avm_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      point_q       <= point_d;
      word_q        <= word_d;
      ch_word_q     <= ch_word_d;
      dwell_cnt_q   <= dwell_cnt_d;
      step_q        <= step_d;
      spacing_q     <= spacing_d;
      npts_q        <= npts_d;
      dwell_q       <= dwell_d;
      abort_pend_q  <= abort_pend_d;
      avm_address_q <= avm_address_d;
      avm_write_q   <= avm_write_d;
      avm_data_q    <= avm_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign avm_address   = avm_address_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = {12'b0, avm_data_q};
  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_point     = point_q;

endmodule

// File: tb/tb_lockin_freq_sweep_master.sv
// Self-checking bench for lockin_freq_sweep_master: table-driven sweeps plus
// hand-written stall, abort, empty-sweep and mid-sweep reset sequences.
`timescale 1ns/1ps
module tb_lockin_freq_sweep_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [19:0] base_word;
  logic [19:0] step_word;
  logic [19:0] chan_spacing;
  logic [15:0] num_points;
  logic [23:0] dwell_cycles;
  logic [15:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic [15:0] cur_point;

  always #5 clk = ~clk;

  lockin_freq_sweep_master dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .base_word       (base_word),
    .step_word       (step_word),
    .chan_spacing    (chan_spacing),
    .num_points      (num_points),
    .dwell_cycles    (dwell_cycles),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .cur_point       (cur_point)
  );

  typedef struct {
    logic [19:0] base;
    logic [19:0] step;
    logic [19:0] spacing;
    logic [15:0] npts;
    logic [23:0] dwell;
    int          exp_writes;
    int          chk_idx;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_gap;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[4];
  wr_t  wq[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   busy_bad = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Writes are recorded half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest)
      wq.push_back('{cyc, avm_address, avm_writedata});
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) busy_bad <= busy_bad + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [19:0] b, input logic [19:0] s, input logic [19:0] sp,
                        input logic [15:0] n, input logic [23:0] d);
    base_word    = b;
    step_word    = s;
    chan_spacing = sp;
    num_points   = n;
    dwell_cycles = d;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      tick();
      t++;
    end
    check(name, (done_cnt != d0), 1);
  endtask

  task automatic wait_addr(input logic [15:0] a, input string name);
    int t;
    t = 0;
    while (!(avm_write && avm_address == a) && t < 200) begin
      tick();
      t++;
    end
    check(name, (avm_write && avm_address == a), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0;
    int          b0;
    int          nw;
    int          t;
    int          p;
    int          ch;
    logic [19:0] md;

    vecs[0] = '{20'd12623,  20'd100,  20'd0, 16'd2, 24'd5, 16, 8,  16'd0,   32'd12723, 5};
    vecs[1] = '{20'hFFFF0,  20'h20,   20'd8, 16'd2, 24'd0, 16, 9,  16'd16,  32'h18,    0};
    vecs[2] = '{20'd0,      20'd0,    20'd0, 16'd0, 24'd3, 0,  -1, 16'd0,   32'd0,     -1};
    vecs[3] = '{20'd5,      20'd1,    20'd3, 16'd3, 24'd1, 24, 23, 16'd112, 32'd28,    1};

    reset_n         = 1'b0;
    start           = 1'b0;
    abort           = 1'b0;
    base_word       = '0;
    step_word       = '0;
    chan_spacing    = '0;
    num_points      = '0;
    dwell_cycles    = '0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    check("reset avm_write", avm_write, 0);
    check("reset avm_address", avm_address, 0);
    check("reset avm_writedata", avm_writedata, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset cur_point", cur_point, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      wq.delete();
      d0 = done_cnt;
      b0 = busy_bad;
      launch(vecs[i].base, vecs[i].step, vecs[i].spacing, vecs[i].npts, vecs[i].dwell);
      check($sformatf("v%0d first write latency", i), avm_write, (vecs[i].npts != 0));
      wait_done(d0, $sformatf("v%0d done seen", i));
      tick();
      tick();
      check($sformatf("v%0d done pulses", i), done_cnt - d0, 1);
      check($sformatf("v%0d busy low at done", i), busy_bad - b0, 0);
      check($sformatf("v%0d write count", i), wq.size(), vecs[i].exp_writes);
      for (int k = 0; k < wq.size(); k++) begin
        p  = k / 8;
        ch = k % 8;
        md = 20'(vecs[i].base + 20'(p) * vecs[i].step + 20'(ch) * vecs[i].spacing);
        check($sformatf("v%0d w%0d addr", i, k), wq[k].addr, 16'(ch * 16));
        check($sformatf("v%0d w%0d data", i, k), wq[k].data, {12'b0, md});
      end
      if (vecs[i].chk_idx >= 0 && vecs[i].chk_idx < wq.size()) begin
        check($sformatf("v%0d hand addr", i), wq[vecs[i].chk_idx].addr, vecs[i].exp_addr);
        check($sformatf("v%0d hand data", i), wq[vecs[i].chk_idx].data, vecs[i].exp_data);
      end
      if (vecs[i].exp_gap >= 0 && wq.size() > 8)
        check($sformatf("v%0d dwell gap", i), wq[8].cyc - wq[7].cyc - 1, vecs[i].exp_gap);
    end

    // Channel 2 stalled for three cycles.
    wq.delete();
    d0 = done_cnt;
    launch(20'd100, 20'd0, 20'd1, 16'd1, 24'd0);
    wait_addr(16'd32, "stall reach ch2");
    avm_waitrequest = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      check($sformatf("stall c%0d write", j), avm_write, 1);
      check($sformatf("stall c%0d addr", j), avm_address, 32);
      check($sformatf("stall c%0d data", j), avm_writedata, 102);
    end
    avm_waitrequest = 1'b0;
    tick();
    check("stall ch3 write", avm_write, 1);
    check("stall ch3 addr", avm_address, 48);
    check("stall ch3 data", avm_writedata, 103);
    wait_done(d0, "stall done seen");
    tick();
    check("stall write count", wq.size(), 8);

    // Abort while channel 4 is stalled, with a stray start during busy.
    wq.delete();
    d0 = done_cnt;
    launch(20'd0, 20'd0, 20'd0, 16'd3, 24'd2);
    wait_addr(16'd64, "abort reach ch4");
    avm_waitrequest = 1'b1;
    abort           = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort ch4 held", (avm_write && avm_address == 16'd64), 1);
    avm_waitrequest = 1'b0;
    tick();
    abort = 1'b0;
    check("abort done", done, 1);
    check("abort busy", busy, 0);
    check("abort write low", avm_write, 0);
    tick();
    check("abort done one cycle", done, 0);
    repeat (20) tick();
    check("abort write count", wq.size(), 5);
    if (wq.size() > 0) check("abort last addr", wq[wq.size() - 1].addr, 64);
    check("abort done pulses", done_cnt - d0, 1);

    // Empty sweep: busy for one cycle, done on the next.
    wq.delete();
    launch(20'd1, 20'd1, 20'd1, 16'd0, 24'd7);
    check("empty busy c1", busy, 1);
    check("empty write c1", avm_write, 0);
    check("empty done c1", done, 0);
    tick();
    check("empty done c2", done, 1);
    check("empty busy c2", busy, 0);
    tick();
    check("empty done c3", done, 0);
    check("empty busy c3", busy, 0);
    check("empty write count", wq.size(), 0);

    // Reset during the dwell of point 3, then a fresh sweep.
    wq.delete();
    launch(20'd7, 20'd1, 20'd0, 16'd5, 24'd10);
    t = 0;
    while (!(cur_point == 16'd3 && !avm_write && busy) && t < 500) begin
      tick();
      t++;
    end
    check("rst reach dwell p3", (cur_point == 16'd3 && !avm_write && busy), 1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst avm_write", avm_write, 0);
    check("rst avm_address", avm_address, 0);
    check("rst avm_writedata", avm_writedata, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst cur_point", cur_point, 0);
    nw = wq.size();
    repeat (15) tick();
    check("rst no writes", wq.size(), nw);
    d0 = done_cnt;
    launch(20'd9, 20'd0, 20'd0, 16'd1, 24'd0);
    check("restart write", avm_write, 1);
    check("restart addr", avm_address, 0);
    check("restart data", avm_writedata, 9);
    check("restart cur_point", cur_point, 0);
    wait_done(d0, "restart done seen");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lockin_freq_sweep_master.md
Name: lockin_freq_sweep_master

Overview:
- Avalon-MM write initiator that steps the NCO frequency-control PIO registers of the lock-in channels through a frequency sweep.
- At each sweep point it writes one 20-bit tuning word to every channel's register, then dwells for a programmable number of clocks before moving to the next point.
- Sits in the Qsys system as a master. It drives the same s1 register ports that the processor otherwise writes.

Parameters:
- CH_COUNT, 8, number of lock-in NCO channels written per point (1..16).
- ADDR_W, 16, Avalon master address width (byte address).
- BASE_ADDR, 16'h0000, byte address of channel 0 frequency register.
- ADDR_STRIDE, 16, byte distance between consecutive channel registers.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- abort  in  1  level; stops the sweep at the next safe point
- base_word  in  20  point-0 tuning word for channel 0
- step_word  in  20  increment added per sweep point
- chan_spacing  in  20  increment added per channel index
- num_points  in  16  sweep points to issue
- dwell_cycles  in  24  idle clocks after each point's last write
- avm_address  out  ADDR_W  byte address of current transfer
- avm_write  out  1  write request
- avm_writedata  out  32  {12'b0, tuning word}
- avm_waitrequest  in  1  slave stall
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle pulse when the sweep ends (completed or aborted)
- cur_point  out  16  index of the point being written or dwelled on

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. Every register is cleared on a clk edge with reset_n=0, whatever the state.
- Reset values: avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0, cur_point=0. The state machine returns to IDLE.
- States are IDLE, WRITE, DWELL and FINISH.
- IDLE:
  - When start=1, latch all config inputs and go to WRITE with ch=0, point=0, word=base_word.
  - If the latched num_points=0, go straight to FINISH and issue no writes.
- WRITE:
  - avm_write=1.
  - avm_address = BASE_ADDR + ch*ADDR_STRIDE (truncated to ADDR_W).
  - avm_writedata = zero-extended (word + ch*chan_spacing) mod 2^20.
  - A transfer is accepted on an edge where avm_write=1 and avm_waitrequest=0.
  - Address and data must stay stable while waitrequest=1. avm_write never drops before acceptance.
  - After acceptance, if ch<CH_COUNT-1, the next channel is presented the very next cycle (back-to-back, no bubble).
  - After the last channel is accepted, load the dwell counter with the latched dwell_cycles and go to DWELL. avm_write=0 in DWELL.
- DWELL:
  - Count down to 0. dwell=0 means a zero-cycle dwell: the next state is evaluated right after the last accept.
  - At expiry, if point<num_points-1: point+1, word = (word + step_word) mod 2^20, ch=0, then WRITE. Otherwise go to FINISH.
- FINISH:
  - done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- Timing:
  - First avm_write is asserted the cycle after start is sampled.
  - Writes per sweep = num_points*CH_COUNT.
  - cur_point updates when WRITE of a new point begins.
- Abort:
  - Sampled every cycle.
  - In WRITE, the pending transfer completes (held until waitrequest=0), then the block goes to FINISH. No further channels are written.
  - In DWELL, it goes to FINISH next cycle.
  - In IDLE, abort has no effect. If abort and start are both high in IDLE, start wins and abort is seen next cycle.
- A start arriving while busy or during FINISH is dropped.
- All additions wrap modulo 2^20 with no saturation. The index counters never overflow because num_points is at most 65535.

Test Plan:
- CH_COUNT=8, base=12623, step=100, spacing=0, points=2, dwell=5, waitrequest=0:
  - 16 writes.
  - Addresses 0,16,...,112, then repeat.
  - Data 12623 ×8, then 12723 ×8.
  - Exactly 5 idle cycles between the two bursts.
  - done pulses once; busy drops with it.
- waitrequest held high 3 cycles on channel 2 write: avm_write, avm_address=32 and avm_writedata stay stable for 4 cycles; channel 3 is presented the cycle after acceptance.
- base=20'hFFFF0, step=20'h20, spacing=8, points=2: point 1 channel 0 data = 20'h00010 and channel 1 = 20'h00018, showing wrap with upper 12 bits zero.
- num_points=0 start: no avm_write at all; done=1 two cycles after start; busy low except for one cycle.
- abort asserted while channel 4 is stalled by waitrequest: the channel 4 write still completes, no channel 5 write, done the following cycle. A second start during busy produces no extra writes.
- reset_n=0 for one cycle during DWELL of point 3: all outputs return to reset values next cycle, no write is issued, and a fresh start restarts at point 0, address BASE_ADDR.
